alu_issue_ctrl: RTL and testbench

Sequential front end for the 16-bit combinational ALU (outputs Z, Sign, Parity, Carry, Overflow, Zero). It accepts operand pairs over a valid/ready handshake and drives them onto the ALU X/Y inputs. After a programmable settle time it captures Z and the five flags into a small result FIFO, which it drains over a second valid/ready handshake. It sits between the operand source (datapath or sequencer) and any result consumer, and decouples both from ALU combinational delay.

---
 rtl/alu_issue_ctrl_pkg.sv | 25 ++
 rtl/alu_issue_ctrl_result_fifo.sv | 66 ++++++
 rtl/alu_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: flag bit positions,
// the packed flag type, FIFO entry geometry and the issue FSM encoding.
package alu_issue_ctrl_pkg;

    localparam int ALU_W        = 16;
    localparam int FLAG_W       = 5;
    localparam int ENTRY_W      = ALU_W + FLAG_W;
    localparam int SETTLE_CNT_W = 4;

    // Bit positions inside the 5-bit flag vector {Sign, Zero, Carry, Parity, Overflow}
    localparam int FLAG_SIGN   = 4;
    localparam int FLAG_ZERO   = 3;
    localparam int FLAG_CARRY  = 2;
    localparam int FLAG_PARITY = 1;
    localparam int FLAG_OVF    = 0;

    typedef logic [FLAG_W-1:0] alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl_result_fifo.sv
// Result FIFO holding captured {Z, flags} words until the consumer takes them.
// Storage carries no reset; only pointers and occupancy are reset, and the
// consumer-facing data is masked by the top while the FIFO is empty.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 21
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: cleared asynchronously so pending entries vanish on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage written at the tail on each push
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential front end for the 16-bit combinational ALU. Accepts operand
// pairs, holds them on the ALU inputs for SETTLE cycles, captures Z and the
// five flags into a result FIFO and drains that FIFO over valid/ready.
// Optional feature: define ALU_STICKY_FLAGS_EN to build the sticky
// {Carry, Overflow} accumulator; otherwise sticky_flags is tied to 0.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ALU_W-1:0]  in_x,
    input  logic [ALU_W-1:0]  in_y,
    output logic [ALU_W-1:0]  alu_x,
    output logic [ALU_W-1:0]  alu_y,
    input  logic [ALU_W-1:0]  alu_z,
    input  logic              alu_sign,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_parity,
    input  logic              alu_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ALU_W-1:0]  out_z,
    output logic [FLAG_W-1:0] out_flags,
    input  logic              sticky_clr,
    output logic [1:0]        sticky_flags
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]           FULL_C      = CW'(DEPTH);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE - 1);

    issue_state_t            state_q, state_d;
    logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
    logic [ALU_W-1:0]        alu_x_q, alu_x_d;
    logic [ALU_W-1:0]        alu_y_q, alu_y_d;
    logic                    in_ready_c;
    logic                    push_c;
    logic                    pop_c;
    logic                    not_full;
    alu_flags_t              cap_flags;
    logic [ENTRY_W-1:0]      head;
    logic [CW-1:0]           count;

    assign not_full = (count < FULL_C);

    // Issue FSM: accept in IDLE, hold operands through SETTLE, push in CAPTURE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        in_ready_c = 1'b0;
        push_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_c = not_full;
                if (in_valid && not_full) begin
                    alu_x_d = in_x;
                    alu_y_d = in_y;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - SETTLE_CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                push_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, settle counter and the operand registers driving the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            alu_x_q <= '0;
            alu_y_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_x_q <= alu_x_d;
            alu_y_q <= alu_y_d;
        end
    end

    // Pack the ALU flags into their fixed bit positions for storage
    always_comb begin
        cap_flags              = '0;
        cap_flags[FLAG_SIGN]   = alu_sign;
        cap_flags[FLAG_ZERO]   = alu_zero;
        cap_flags[FLAG_CARRY]  = alu_carry;
        cap_flags[FLAG_PARITY] = alu_parity;
        cap_flags[FLAG_OVF]    = alu_overflow;
    end

    assign pop_c = out_valid && out_ready;

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i ({alu_z, cap_flags}),
        .rdata_o (head),
        .count_o (count)
    );

    // in_ready is held low while reset is asserted even though the FSM already sits in IDLE
    assign in_ready  = rst_n && in_ready_c;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign out_valid = (count != '0);
    // Head data is masked when empty so the outputs read 0 out of reset
    assign out_z     = out_valid ? head[ENTRY_W-1:FLAG_W] : '0;
    assign out_flags = out_valid ? head[FLAG_W-1:0]       : '0;

`ifdef ALU_STICKY_FLAGS_EN
    logic [1:0] sticky_q, sticky_d;

    // Clear takes effect first, then the same cycle's capture is OR-ed in
    always_comb begin
        sticky_d = sticky_clr ? 2'b00 : sticky_q;
        if (push_c) begin
            sticky_d = sticky_d | {alu_carry, alu_overflow};
        end
    end

    // Sticky {Carry, Overflow} accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_flags      = 2'b00;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a scoreboard of expected results.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, sticky_clr;
    logic [15:0] in_x, in_y, alu_x, alu_y, alu_z, out_z;
    logic        alu_sign, alu_zero, alu_carry, alu_parity, alu_overflow;
    logic [4:0]  out_flags;
    logic [1:0]  sticky_flags;

    logic        in3_valid, in3_ready, out3_valid, out3_ready, sticky3_clr;
    logic [15:0] in3_x, in3_y, alu3_x, alu3_y, alu3_z, out3_z;
    logic        alu3_sign, alu3_zero, alu3_carry, alu3_parity, alu3_overflow;
    logic [4:0]  out3_flags;
    logic [1:0]  sticky3_flags;

    int checks   = 0;
    int failures = 0;
    logic [20:0] sb[$];

    always #5 clk = ~clk;

    // Reference adder: returns {Z, Sign, Zero, Carry, Parity, Overflow}
    function automatic logic [20:0] alu_model(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        logic [15:0] z;
        logic v;
        s = {1'b0, x} + {1'b0, y};
        z = s[15:0];
        v = (x[15] == y[15]) && (z[15] != x[15]);
        return {z, z[15], (z == 16'h0000), s[16], ^z, v};
    endfunction

    assign {alu_z, alu_sign, alu_zero, alu_carry, alu_parity, alu_overflow} = alu_model(alu_x, alu_y);
    assign {alu3_z, alu3_sign, alu3_zero, alu3_carry, alu3_parity, alu3_overflow} = alu_model(alu3_x, alu3_y);

    alu_issue_ctrl #(.SETTLE(1), .DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
        .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_parity(alu_parity), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags),
        .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
    );

    alu_issue_ctrl #(.SETTLE(3), .DEPTH(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in3_valid), .in_ready(in3_ready), .in_x(in3_x), .in_y(in3_y),
        .alu_x(alu3_x), .alu_y(alu3_y), .alu_z(alu3_z),
        .alu_sign(alu3_sign), .alu_zero(alu3_zero), .alu_carry(alu3_carry),
        .alu_parity(alu3_parity), .alu_overflow(alu3_overflow),
        .out_valid(out3_valid), .out_ready(out3_ready), .out_z(out3_z), .out_flags(out3_flags),
        .sticky_clr(sticky3_clr), .sticky_flags(sticky3_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one operand pair on the SETTLE=1 instance and wait for acceptance
    task automatic send(input logic [15:0] x, input logic [15:0] y);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        in_x = x; in_y = y; in_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("accept", 32'(done), 32'd1);
    endtask

    // Scoreboard: record on input handshake, compare on output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sb.push_back(alu_model(in_x, in_y));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_pop", 32'd1, 32'd0);
                end else begin
                    logic [20:0] e;
                    e = sb.pop_front();
                    chk("sb_z", 32'(out_z), 32'(e[20:5]));
                    chk("sb_flags", 32'(out_flags), 32'(e[4:0]));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        rst_n = 1'b0;
        in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0; sticky_clr = 1'b0;
        in3_valid = 1'b0; in3_x = '0; in3_y = '0; out3_ready = 1'b0; sticky3_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_z", 32'(out_z), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_alu_x", 32'(alu_x), 32'd0);
        chk("rst_alu_y", 32'(alu_y), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        chk("rst_sticky3", 32'(sticky3_flags), 32'd0);
        chk("rst_in3_ready", 32'(in3_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Basic add 8fff + 8000
        out_ready = 1'b1;
        send(16'h8fff, 16'h8000);
        @(negedge clk);
        chk("add_alu_x", 32'(alu_x), 32'h8fff);
        chk("add_alu_y", 32'(alu_y), 32'h8000);
        chk("add_valid_n0", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("add_valid_n1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("add_valid_n2", 32'(out_valid), 32'd1);
        chk("add_z", 32'(out_z), 32'h0fff);
        chk("add_flags", 32'(out_flags), 32'b00101);

        // Zero result fffe + 0002
        send(16'hfffe, 16'h0002);
        repeat (3) @(negedge clk);
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero_z", 32'(out_z), 32'h0000);
        chk("zero_flags", 32'(out_flags), 32'b01100);

        // Back-pressure with DEPTH=4
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h1111, 16'h0001);
        send(16'h2222, 16'h0002);
        send(16'h3333, 16'h0003);
        send(16'h4444, 16'h0004);
        repeat (3) @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_head_z", 32'(out_z), 32'h1112);
        @(posedge clk); #1;
        in_x = 16'h5555; in_y = 16'h0005; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_hold_ready", 32'(in_ready), 32'd0);
        chk("full_hold_z", 32'(out_z), 32'h1112);
        chk("full_hold_flags", 32'(out_flags), 32'b00000);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_ready", 32'(in_ready), 32'd1);
        chk("after_pop_head", 32'(out_z), 32'h2224);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0) ok = 1'b1;
        end
        chk("bp_drain", 32'(ok), 32'd1);
        @(negedge clk);
        chk("bp_empty", 32'(out_valid), 32'd0);

`ifdef ALU_STICKY_FLAGS_EN
        send(16'h8fff, 16'h8000);
        repeat (3) @(negedge clk);
        chk("sticky_set", 32'(sticky_flags), 32'b11);
        send(16'h0001, 16'h0001);
        repeat (3) @(negedge clk);
        chk("sticky_hold", 32'(sticky_flags), 32'b11);
        @(posedge clk); #1;
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr", 32'(sticky_flags), 32'b00);
        send(16'h8fff, 16'h8000);
        @(posedge clk); #1;
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr_capture", 32'(sticky_flags), 32'b11);
`else
        send(16'h8fff, 16'h8000);
        @(posedge clk); #1;
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky_off", 32'(sticky_flags), 32'b00);
`endif

        // SETTLE=3 instance: operands held while inputs toggle
        @(posedge clk); #1;
        out3_ready = 1'b1;
        in3_x = 16'h7000; in3_y = 16'h1000; in3_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (in3_ready) ok = 1'b1;
        end
        chk("s3_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        in3_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s3_alu_x", 32'(alu3_x), 32'h7000);
            chk("s3_alu_y", 32'(alu3_y), 32'h1000);
            chk("s3_valid_low", 32'(out3_valid), 32'd0);
            in3_x = in3_x ^ 16'hffff;
            in3_y = in3_y ^ 16'h5a5a;
        end
        @(negedge clk);
        chk("s3_valid", 32'(out3_valid), 32'd1);
        chk("s3_z", 32'(out3_z), 32'h8000);
        chk("s3_flags", 32'(out3_flags), 32'b10011);

        // Reset mid-SETTLE with two entries pending
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'haaaa, 16'h1111);
        send(16'hbbbb, 16'h2222);
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        send(16'hcccc, 16'h3333);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_alu_x", 32'(alu_x), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_sticky", 32'(sticky_flags), 32'b00);
        chk("post_rst_z", 32'(out_z), 32'd0);

        // Fresh operation after reset
        out_ready = 1'b1;
        send(16'h0005, 16'h0003);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0) ok = 1'b1;
        end
        chk("final_drain", 32'(ok), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
